// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - widths, types and saturation helper shared by the IIR filter
package iir_pkg;
   localparam int X_W    = 16;
   localparam int COEF_W = 16;
   localparam int FRAC   = 14;
   localparam int DATA_W = 32;
   localparam int ACC_W  = 64;

   typedef logic signed [X_W-1:0]    sample_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [DATA_W-1:0] data_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   localparam acc_t DATA_MAX = 64'sd2147483647;
   localparam acc_t DATA_MIN = -64'sd2147483648;

   function automatic data_t sat32(acc_t v);
      if (v > DATA_MAX)
         return data_t'(32'sh7FFFFFFF);
      else if (v < DATA_MIN)
         return data_t'(32'sh80000000);
      else
         return v[DATA_W-1:0];
   endfunction
endpackage

// File: rtl/iir_filter_if.sv
// rtl/iir_filter_if.sv - sample stream into and filtered stream out of the IIR filter
interface iir_filter_if;
   import iir_pkg::*;

   sample_t x;
   data_t   y;

   modport master (output x, input y);
   modport slave  (input x, output y);
endinterface

// File: rtl/iir_biquad.sv
// rtl/iir_biquad.sv - one direct-form-I biquad section with saturated registered output
module iir_biquad
   import iir_pkg::*;
#(
   parameter coef_t B0 = 16'sd16384,
   parameter coef_t B1 = 16'sd0,
   parameter coef_t B2 = 16'sd0,
   parameter coef_t A1 = 16'sd0,
   parameter coef_t A2 = 16'sd0
) (
   input  logic  clk,
   input  logic  rst,
   input  data_t u,
   output data_t w
);
   data_t u1;
   data_t u2;
   data_t w2;
   acc_t  acc;

   // 64-bit operands keep every product and the running sum exact.
   always_comb begin
      acc = acc_t'(B0) * acc_t'(u)
          + acc_t'(B1) * acc_t'(u1)
          + acc_t'(B2) * acc_t'(u2)
          - acc_t'(A1) * acc_t'(w)
          - acc_t'(A2) * acc_t'(w2);
   end

   // Feedback taps hold the saturated values, so a clamped section cannot run away.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         u1 <= '0;
         u2 <= '0;
         w  <= '0;
         w2 <= '0;
      end else begin
         u1 <= u;
         u2 <= u1;
         w2 <= w;
         w  <= sat32(acc >>> FRAC);
      end
   end
endmodule

// File: rtl/iir_filter.sv
// rtl/iir_filter.sv - two cascaded biquad sections, one sample per clock, no handshake
module iir_filter
   import iir_pkg::*;
#(
   parameter coef_t S1_B0 = 16'sd16384,
   parameter coef_t S1_B1 = 16'sd0,
   parameter coef_t S1_B2 = 16'sd0,
   parameter coef_t S1_A1 = -16'sd8192,
   parameter coef_t S1_A2 = 16'sd0,
   parameter coef_t S2_B0 = 16'sd16384,
   parameter coef_t S2_B1 = 16'sd0,
   parameter coef_t S2_B2 = 16'sd0,
   parameter coef_t S2_A1 = 16'sd0,
   parameter coef_t S2_A2 = 16'sd0
) (
   input  logic         clk,
   input  logic         rst,
   iir_filter_if.slave  bus
);
   data_t u0;
   data_t s1;
   data_t w2;

   assign u0 = data_t'(bus.x);

   iir_biquad #(
      .B0(S1_B0), .B1(S1_B1), .B2(S1_B2), .A1(S1_A1), .A2(S1_A2)
   ) u_sec1 (
      .clk (clk),
      .rst (rst),
      .u   (u0),
      .w   (s1)
   );

   iir_biquad #(
      .B0(S2_B0), .B1(S2_B1), .B2(S2_B2), .A1(S2_A1), .A2(S2_A2)
   ) u_sec2 (
      .clk (clk),
      .rst (rst),
      .u   (s1),
      .w   (w2)
   );

   assign bus.y = w2;
endmodule

// File: tb/tb_iir_filter.sv
// tb/tb_iir_filter.sv - directed bench for iir_filter with a difference-equation model
module tb_iir_filter;
   import iir_pkg::*;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   vecs;
   int   errs;

   iir_filter_if if_a ();
   iir_filter_if if_b ();

   iir_filter dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (if_a)
   );

   iir_filter #(
      .S1_B0(16'sd32767),
      .S1_A1(-16'sd16384)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state per [dut][section]: input and output history of the difference equation.
   longint cb0 [2][2];
   longint cb1 [2][2];
   longint cb2 [2][2];
   longint ca1 [2][2];
   longint ca2 [2][2];
   longint mu1 [2][2];
   longint mu2 [2][2];
   longint mw1 [2][2];
   longint mw2 [2][2];

   function automatic longint clamp(longint v);
      if (v > 64'sd2147483647)
         return 64'sd2147483647;
      if (v < -64'sd2147483648)
         return -64'sd2147483648;
      return v;
   endfunction

   function automatic longint sec(int d, int s, longint u);
      longint acc;
      acc = cb0[d][s] * u + cb1[d][s] * mu1[d][s] + cb2[d][s] * mu2[d][s]
          - ca1[d][s] * mw1[d][s] - ca2[d][s] * mw2[d][s];
      return clamp(acc >>> 14);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step();
      logic [1:0] r;
      longint     u0;
      longint     w1n;
      longint     w2n;
      longint     s1_old;
      r = {rst_b, rst_a};
      for (int d = 0; d < 2; d++) begin
         if (!r[d]) begin
            for (int s = 0; s < 2; s++) begin
               mu1[d][s] = 0;
               mu2[d][s] = 0;
               mw1[d][s] = 0;
               mw2[d][s] = 0;
            end
         end else begin
            u0     = (d == 0) ? longint'(if_a.x) : longint'(if_b.x);
            s1_old = mw1[d][0];
            w1n    = sec(d, 0, u0);
            w2n    = sec(d, 1, s1_old);
            mu2[d][0] = mu1[d][0];
            mu1[d][0] = u0;
            mw2[d][0] = mw1[d][0];
            mw1[d][0] = w1n;
            mu2[d][1] = mu1[d][1];
            mu1[d][1] = s1_old;
            mw2[d][1] = mw1[d][1];
            mw1[d][1] = w2n;
         end
      end
   endtask

   // While reset is low the output must already be zero, before any clock edge.
   task automatic compare();
      check("model_a", longint'(if_a.y), rst_a ? mw1[0][1] : 0);
      check("model_b", longint'(if_b.y), rst_b ? mw1[1][1] : 0);
   endtask

   task automatic tick(input sample_t va, input sample_t vb);
      if_a.x = va;
      if_b.x = vb;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      #1;
   endtask

   longint step_exp [5];
   longint neg_exp  [4];
   bit     done;

   initial begin
      vecs = 0;
      errs = 0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      if_a.x = '0;
      if_b.x = '0;
      for (int d = 0; d < 2; d++) begin
         for (int s = 0; s < 2; s++) begin
            cb0[d][s] = 16384; cb1[d][s] = 0; cb2[d][s] = 0;
            ca1[d][s] = 0;     ca2[d][s] = 0;
            mu1[d][s] = 0; mu2[d][s] = 0; mw1[d][s] = 0; mw2[d][s] = 0;
         end
      end
      ca1[0][0] = -8192;
      cb0[1][0] = 32767;
      ca1[1][0] = -16384;
      step_exp = '{0, 16384, 24576, 28672, 30720};
      neg_exp  = '{0, -16384, -24576, -28672};

      @(negedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         tick((i % 2) ? 16'sh7FFF : 16'sh8000, (i % 2) ? 16'sh8000 : 16'sh7FFF);
         check("reset_hold_y", longint'(if_a.y), 0);
      end

      rst_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(16'sd0, 16'sd0);
         check("post_release_y", longint'(if_a.y), 0);
      end

      tick(16'sh4000, 16'sd0);
      check("impulse_lat", longint'(if_a.y), 0);
      for (int k = 0; k < 18; k++) begin
         tick(16'sd0, 16'sd0);
         check("impulse_y", longint'(if_a.y), (k <= 14) ? (64'sd16384 >>> k) : 0);
      end

      for (int k = 0; k < 40; k++) begin
         tick(16'sh4000, 16'sd0);
         if (k < 5)
            check("step_y", longint'(if_a.y), step_exp[k]);
         check("step_overshoot", (longint'(if_a.y) > 32767) ? 1 : 0, 0);
      end
      check("step_settle", longint'(if_a.y), 32767);

      @(posedge clk);
      model_step();
      #2 rst_a = 1'b0;
      @(negedge clk);
      compare();
      check("async_reset_y", longint'(if_a.y), 0);
      #1;
      tick(16'sh4000, 16'sd0);
      rst_a = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick(16'sh4000, 16'sd0);
         check("restart_y", longint'(if_a.y), step_exp[k]);
      end

      rst_a = 1'b0;
      tick(16'sd0, 16'sd0);
      rst_a = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick(-16'sd16384, 16'sd0);
         if (k < 4)
            check("neg_step_y", longint'(if_a.y), neg_exp[k]);
      end
      check("neg_settle", longint'(if_a.y), -32768);

      rst_b = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 40000 && !done; i++) begin
         tick(16'sd0, 16'sh7FFF);
         check("sat_pos_nowrap", (longint'(if_b.y) < 0) ? 1 : 0, 0);
         done = (longint'(if_b.y) == 64'sd2147483647);
      end
      check("sat_pos_reached", longint'(if_b.y), 64'sd2147483647);
      tick(16'sd0, 16'sh7FFF);
      check("sat_pos_hold", longint'(if_b.y), 64'sd2147483647);

      rst_b = 1'b0;
      tick(16'sd0, 16'sd0);
      rst_b = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 40000 && !done; i++) begin
         tick(16'sd0, 16'sh8000);
         check("sat_neg_nowrap", (longint'(if_b.y) > 0) ? 1 : 0, 0);
         done = (longint'(if_b.y) == -64'sd2147483648);
      end
      check("sat_neg_reached", longint'(if_b.y), -64'sd2147483648);
      tick(16'sd0, 16'sh8000);
      check("sat_neg_hold", longint'(if_b.y), -64'sd2147483648);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
